// File: rtl/regex_ctrl_pkg.sv
// ============================================================================
// Module  : regex_ctrl_pkg
// Brief   : Shared state encoding and default parameters for regex_stream_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regex_ctrl_pkg;

    localparam int DEF_POS_W        = 32;
    localparam int DEF_START_CYCLES = 2;
`ifdef REGEX_CTRL_TIMEOUT_EN
    localparam int DEF_TIMEOUT_CYCLES = 1024;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regex_result_reg.sv
// ============================================================================
// Module  : regex_result_reg
// Brief   : Match-result holding register (valid/ready) that drops repeats of
//           the previously reported span.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regex_result_reg
    import regex_ctrl_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             match_i,
    input  logic [POS_W-1:0] start_i,
    input  logic [POS_W-1:0] end_i,
    output logic             is_new_o,
    input  logic             res_ready_i,
    output logic             res_valid_o,
    output logic [POS_W-1:0] res_start_o,
    output logic [POS_W-1:0] res_end_o
);

    logic             have_prev_q;
    logic             res_valid_q;
    logic [POS_W-1:0] res_start_q;
    logic [POS_W-1:0] res_end_q;

    // The held result doubles as the previous span: it is only overwritten by a new one.
    assign is_new_o = match_i &&
                      (!have_prev_q || (start_i != res_start_q) || (end_i != res_end_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            have_prev_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_start_q <= '0;
            res_end_q   <= '0;
        end else begin
            if (load_i && is_new_o) begin
                have_prev_q <= 1'b1;
                res_valid_q <= 1'b1;
                res_start_q <= start_i;
                res_end_q   <= end_i;
            end else if (res_valid_q && res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_start_o = res_start_q;
    assign res_end_o   = res_end_q;

endmodule

`default_nettype wire

// File: rtl/regex_stream_ctrl.sv
// ============================================================================
// Module  : regex_stream_ctrl
// Brief   : Byte-stream sequencer for a one-char-at-a-time regex detector.
//           Optional det_rdy watchdog enabled by macro REGEX_CTRL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regex_stream_ctrl
    import regex_ctrl_pkg::*;
#(
    parameter int POS_W        = DEF_POS_W,
    parameter int START_CYCLES = DEF_START_CYCLES
`ifdef REGEX_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             in_ready,
    output logic             det_start,
    output logic [7:0]       det_char,
    output logic             det_last,
    input  logic             det_rdy,
    input  logic             det_match,
    input  logic [POS_W-1:0] det_start_pos,
    input  logic [POS_W-1:0] det_end_pos,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [POS_W-1:0] res_start,
    output logic [POS_W-1:0] res_end,
    output logic [POS_W-1:0] char_cnt,
    output logic             done,
    output logic             err
);

    localparam int               SC_W    = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    state_t           state_q;
    logic             in_ready_q;
    logic             det_start_q;
    logic             done_q;
    logic [7:0]       det_char_q;
    logic             det_last_q;
    logic [SC_W-1:0]  launch_cnt_q;
    logic [POS_W-1:0] char_cnt_q;
    logic [POS_W-1:0] char_cnt_d;
    logic             match_q;
    logic [POS_W-1:0] mstart_q;
    logic [POS_W-1:0] mend_q;
    logic             is_new;
    logic             wait_timeout;

    assign char_cnt_d = (&char_cnt_q) ? char_cnt_q : (char_cnt_q + POS_ONE);

`ifdef REGEX_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] wait_cnt_q;
    logic            err_q;

    assign wait_timeout = (state_q == ST_WAIT) && !det_rdy &&
                          (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q != ST_WAIT) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + TO_W'(1);
            end
            if (wait_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wait_timeout = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            det_start_q  <= 1'b0;
            done_q       <= 1'b0;
            det_char_q   <= '0;
            det_last_q   <= 1'b0;
            launch_cnt_q <= '0;
            char_cnt_q   <= '0;
            match_q      <= 1'b0;
            mstart_q     <= '0;
            mend_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        det_char_q   <= in_char;
                        det_last_q   <= in_last;
                        in_ready_q   <= 1'b0;
                        det_start_q  <= 1'b1;
                        launch_cnt_q <= '0;
                        state_q      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (launch_cnt_q == SC_LAST) begin
                        det_start_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else begin
                        launch_cnt_q <= launch_cnt_q + SC_ONE;
                    end
                end
                ST_WAIT: begin
                    // A watchdog expiry is handled as a completed byte without a match.
                    if (det_rdy || wait_timeout) begin
                        if (!det_last_q) begin
                            char_cnt_q <= char_cnt_d;
                        end
                        match_q  <= det_rdy && det_match;
                        mstart_q <= det_start_pos;
                        mend_q   <= det_end_pos;
                        state_q  <= det_rdy ? ST_CHECK : ST_NEXT;
                    end
                end
                ST_CHECK: begin
                    state_q <= is_new ? ST_REPORT : ST_NEXT;
                end
                ST_REPORT: begin
                    if (res_valid && res_ready) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (det_last_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    regex_result_reg #(
        .POS_W (POS_W)
    ) u_result (
        .clk         (clk),
        .reset       (reset),
        .load_i      (state_q == ST_CHECK),
        .match_i     (match_q),
        .start_i     (mstart_q),
        .end_i       (mend_q),
        .is_new_o    (is_new),
        .res_ready_i (res_ready),
        .res_valid_o (res_valid),
        .res_start_o (res_start),
        .res_end_o   (res_end)
    );

    assign in_ready  = in_ready_q;
    assign det_start = det_start_q;
    assign det_char  = det_char_q;
    assign det_last  = det_last_q;
    assign char_cnt  = char_cnt_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regex_stream_ctrl.sv
// ============================================================================
// Module  : tb_regex_stream_ctrl
// Brief   : Self-checking bench for regex_stream_ctrl with a detector stub and
//           a transaction-level expectation model (REGEX_CTRL_TIMEOUT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regex_stream_ctrl;

    localparam int POS_W = 4;
    localparam int SC    = 2;
    localparam int TO    = 8;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_char = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             det_start;
    logic [7:0]       det_char;
    logic             det_last;
    logic             det_rdy = 1'b0;
    logic             det_match;
    logic [POS_W-1:0] det_start_pos;
    logic [POS_W-1:0] det_end_pos;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [POS_W-1:0] res_start;
    logic [POS_W-1:0] res_end;
    logic [POS_W-1:0] char_cnt;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    regex_stream_ctrl #(
        .POS_W        (POS_W),
        .START_CYCLES (SC)
`ifdef REGEX_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_char       (in_char),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .det_start     (det_start),
        .det_char      (det_char),
        .det_last      (det_last),
        .det_rdy       (det_rdy),
        .det_match     (det_match),
        .det_start_pos (det_start_pos),
        .det_end_pos   (det_end_pos),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_start     (res_start),
        .res_end       (res_end),
        .char_cnt      (char_cnt),
        .done          (done),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Detector stub: rdy stub_dly cycles after start falls, match data held per byte.
    logic             stub_m = 1'b0;
    logic [POS_W-1:0] stub_s = '0;
    logic [POS_W-1:0] stub_e = '0;
    int               stub_dly = 3;
    bit               stub_never = 1'b0;
    bit               launch_glitch = 1'b0;
    int               scnt = 0;

    assign det_match     = stub_m;
    assign det_start_pos = stub_s;
    assign det_end_pos   = stub_e;

    always @(negedge clk) begin
        if (!reset || det_start) begin
            scnt    = 0;
            det_rdy = det_start && launch_glitch;
        end else begin
            scnt++;
            det_rdy = !stub_never && (scnt >= stub_dly);
        end
    end

    // Sink backpressure: res_ready low for bp_hold cycles of res_valid.
    int bp_hold = 0;
    int bp_cnt  = 0;

    always @(posedge clk) begin
        #2;
        if (res_valid && (bp_cnt < bp_hold)) begin
            res_ready = 1'b0;
            bp_cnt++;
        end else begin
            res_ready = 1'b1;
        end
    end

    // Expectation model
    logic [7:0]       exp_q[$];
    bit               have_prev_m = 1'b0;
    logic [POS_W-1:0] prev_s_m = '0;
    logic [POS_W-1:0] prev_e_m = '0;
    int               cnt_m = 0;

    // Monitor state
    bit               mon_en = 1'b0;
    int               run = 0;
    int               pulses = 0;
    int               res_seen = 0;
    logic             pv = 1'b0;
    logic             pr = 1'b0;
    logic [POS_W-1:0] ps_s = '0;
    logic [POS_W-1:0] ps_e = '0;
    logic [POS_W-1:0] last_s = '0;
    logic [POS_W-1:0] last_e = '0;
    logic [7:0]       ent;

    always @(negedge clk) begin
        if (!reset || !mon_en) begin
            run = 0;
            pv  = 1'b0;
            pr  = 1'b0;
        end else begin
            if (det_start) begin
                run++;
            end else if (run != 0) begin
                chk("det_start width", 32'(run), 32'(SC));
                pulses++;
                run = 0;
            end
            if (res_valid) begin
                chk("in_ready low during result", 32'(in_ready), 32'd0);
                if (pv && !pr) begin
                    chk("res_start stable", 32'(res_start), 32'(ps_s));
                    chk("res_end stable", 32'(res_end), 32'(ps_e));
                end else begin
                    res_seen++;
                    last_s = res_start;
                    last_e = res_end;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected result: got start %0d end %0d, expected none",
                                 res_start, res_end);
                    end else begin
                        ent = exp_q.pop_front();
                        chk("res_start", 32'(res_start), 32'(ent[7:4]));
                        chk("res_end", 32'(res_end), 32'(ent[3:0]));
                    end
                end
            end
            if (done) begin
                chk("in_ready low when done", 32'(in_ready), 32'd0);
            end
`ifndef REGEX_CTRL_TIMEOUT_EN
            chk("err tied low", 32'(err), 32'd0);
`endif
            pv   = res_valid;
            pr   = res_ready;
            ps_s = res_start;
            ps_e = res_end;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        have_prev_m = 1'b0;
        prev_s_m    = '0;
        prev_e_m    = '0;
        cnt_m       = 0;
        pulses      = 0;
        res_seen    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst det_start", 32'(det_start), 32'd0);
        chk("rst det_char", 32'(det_char), 32'd0);
        chk("rst det_last", 32'(det_last), 32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_start", 32'(res_start), 32'd0);
        chk("rst res_end", 32'(res_end), 32'd0);
        chk("rst char_cnt", 32'(char_cnt), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        stub_never    = 1'b0;
        launch_glitch = 1'b0;
        stub_m        = 1'b0;
        bp_hold       = 0;
        bp_cnt        = 0;
        model_clear();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] c, input logic last, input int dly,
                             input logic m, input logic [POS_W-1:0] s,
                             input logic [POS_W-1:0] e, input int extra);
        bit fresh;
        int lat;
        int n;
        stub_dly = dly;
        stub_m   = m;
        stub_s   = s;
        stub_e   = e;
        fresh = m && (!have_prev_m || (s != prev_s_m) || (e != prev_e_m));
        if (fresh) begin
            exp_q.push_back({s, e});
            have_prev_m = 1'b1;
            prev_s_m    = s;
            prev_e_m    = e;
        end
        if (!last && (cnt_m != SAT)) cnt_m++;
        lat = SC + dly + 3 + (fresh ? (1 + extra) : 0);
        @(negedge clk);
        n = 0;
        while (!in_ready && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("det_char", 32'(det_char), 32'(c));
        chk("det_last", 32'(det_last), 32'(last));
        chk("det_start raised", 32'(det_start), 32'd1);
        n = 1;
        while (!in_ready && !done && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        chk("byte latency", 32'(n), 32'(lat));
        chk("char_cnt", 32'(char_cnt), 32'(cnt_m));
    endtask

    logic             m_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [POS_W-1:0] s_tab [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [POS_W-1:0] e_tab [6] = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd3, 4'd5};

    initial begin
        do_reset();
        mon_en = 1'b1;

        // "ab" then last, no match
        send_byte(8'h61, 1'b0, 3, 1'b0, 4'd0, 4'd0, 0);
        send_byte(8'h62, 1'b0, 3, 1'b0, 4'd0, 4'd0, 0);
        send_byte(8'h00, 1'b1, 3, 1'b0, 4'd0, 4'd0, 0);
        repeat (5) @(negedge clk);
        chk("ab pulses", 32'(pulses), 32'd3);
        chk("ab char_cnt", 32'(char_cnt), 32'd2);
        chk("ab done", 32'(done), 32'd1);
        chk("ab results", 32'(res_seen), 32'd0);

        // Repeated span deduplicated, then a new span; det_rdy during LAUNCH ignored
        do_reset();
        launch_glitch = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h31 + i), 1'b0, 2, m_tab[i], s_tab[i], e_tab[i], 0);
        end
        send_byte(8'h00, 1'b1, 2, 1'b0, 4'd0, 4'd0, 0);
        chk("dedupe result count", 32'(res_seen), 32'd2);
        chk("dedupe last start", 32'(last_s), 32'd1);
        chk("dedupe last end", 32'(last_e), 32'd5);
        chk("dedupe queue drained", 32'(exp_q.size()), 32'd0);
        chk("dedupe char_cnt", 32'(char_cnt), 32'd6);

        // Sink backpressure for 10 cycles
        do_reset();
        bp_hold = 10;
        bp_cnt  = 0;
        send_byte(8'h78, 1'b0, 2, 1'b1, 4'd2, 4'd4, 10);
        chk("bp result count", 32'(res_seen), 32'd1);
        chk("bp start", 32'(last_s), 32'd2);
        chk("bp end", 32'(last_e), 32'd4);
        send_byte(8'h79, 1'b0, 2, 1'b1, 4'd2, 4'd4, 0);
        send_byte(8'h00, 1'b1, 2, 1'b0, 4'd0, 4'd0, 0);
        chk("bp no repeat", 32'(res_seen), 32'd1);
        chk("bp done", 32'(done), 32'd1);

        // Reset during WAIT
        do_reset();
        stub_dly = 50;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'h41;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (SC + 2) @(negedge clk);
        chk("wait det_start", 32'(det_start), 32'd0);
        chk("wait in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort det_start", 32'(det_start), 32'd0);
        chk("abort det_char", 32'(det_char), 32'd0);
        chk("abort char_cnt", 32'(char_cnt), 32'd0);
        chk("abort res_valid", 32'(res_valid), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        model_clear();
        reset = 1'b1;
        send_byte(8'h42, 1'b0, 2, 1'b0, 4'd0, 4'd0, 0);
        chk("restart char_cnt", 32'(char_cnt), 32'd1);

        // Immediate end-of-stream marker
        do_reset();
        send_byte(8'h00, 1'b1, 3, 1'b0, 4'd0, 4'd0, 0);
        repeat (3) @(negedge clk);
        chk("empty pulses", 32'(pulses), 32'd1);
        chk("empty det_last", 32'(det_last), 32'd1);
        chk("empty char_cnt", 32'(char_cnt), 32'd0);
        chk("empty done", 32'(done), 32'd1);

        // char_cnt saturation
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b0, 1, 1'b0, 4'd0, 4'd0, 0);
            if (i == 14) chk("sat reach", 32'(char_cnt), 32'd15);
        end
        chk("sat hold", 32'(char_cnt), 32'd15);
        send_byte(8'h00, 1'b1, 1, 1'b0, 4'd0, 4'd0, 0);
        chk("sat done", 32'(done), 32'd1);

        // Detector never ready
        do_reset();
        stub_never = 1'b1;
`ifdef REGEX_CTRL_TIMEOUT_EN
        send_byte(8'h55, 1'b0, TO - 1, 1'b0, 4'd0, 4'd0, 0);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout char_cnt", 32'(char_cnt), 32'd1);
        stub_never = 1'b0;
        send_byte(8'h56, 1'b0, 2, 1'b0, 4'd0, 4'd0, 0);
        chk("timeout err sticky", 32'(err), 32'd1);
`else
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'h55;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall err", 32'(err), 32'd0);
        chk("stall det_start", 32'(det_start), 32'd0);
        chk("stall char_cnt", 32'(char_cnt), 32'd0);
`endif
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
